// File: rtl/ex_mem_pipe.sv
// EX/MEM pipeline stage: registered ALU result plus MEM/WB control, with a valid/ready handshake
// backed by a 2-entry skid buffer, branch resolution and a saturating stall counter.
module ex_mem_pipe #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [DATA_WIDTH-1:0] alu_data_i,
    input  logic                  zero_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [REG_ADDR_W-1:0] rd_i,
    input  logic [3:0]            ctrl_i,
    input  logic                  branch_i,
    input  logic [DATA_WIDTH-1:0] btarget_i,
    input  logic                  flush_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [DATA_WIDTH-1:0] alu_data_o,
    output logic [DATA_WIDTH-1:0] wdata_o,
    output logic [REG_ADDR_W-1:0] rd_o,
    output logic [3:0]            ctrl_o,
    output logic                  branch_taken_o,
    output logic [DATA_WIDTH-1:0] btarget_o,
    output logic [CNT_W-1:0]      stall_cnt_o
);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] alu_data;
        logic                  zero;
        logic [DATA_WIDTH-1:0] wdata;
        logic [REG_ADDR_W-1:0] rd;
        logic [3:0]            ctrl;
        logic                  branch;
        logic [DATA_WIDTH-1:0] btarget;
    } entry_t;

    entry_t           in_entry;
    entry_t           o_q, o_d, s_q, s_d;
    logic             o_valid_q, o_valid_d, s_valid_q, s_valid_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             up_xfer, down_xfer;

    assign in_entry = '{
        alu_data: alu_data_i,
        zero:     zero_i,
        wdata:    wdata_i,
        rd:       rd_i,
        ctrl:     ctrl_i,
        branch:   branch_i,
        btarget:  btarget_i
    };

    // Readiness is purely a function of skid occupancy, so it never depends on ready_i.
    assign ready_o   = ~s_valid_q;
    assign up_xfer   = valid_i & ~s_valid_q;
    assign down_xfer = o_valid_q & ready_i;

    always_comb begin
        o_d       = o_q;
        s_d       = s_q;
        o_valid_d = o_valid_q;
        s_valid_d = s_valid_q;
        if (flush_i) begin
            o_valid_d = 1'b0;
            s_valid_d = 1'b0;
        end else if (!o_valid_q || down_xfer) begin
            if (s_valid_q) begin
                o_d       = s_q;
                o_valid_d = 1'b1;
                s_valid_d = 1'b0;
            end else begin
                o_valid_d = up_xfer;
                if (up_xfer) begin
                    o_d = in_entry;
                end
            end
        end else if (up_xfer) begin
            s_d       = in_entry;
            s_valid_d = 1'b1;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (o_valid_q && !ready_i && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            o_q         <= '0;
            s_q         <= '0;
            o_valid_q   <= 1'b0;
            s_valid_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            o_q         <= o_d;
            s_q         <= s_d;
            o_valid_q   <= o_valid_d;
            s_valid_q   <= s_valid_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Control and branch outcome are gated so bubbles cannot write registers or memory.
    assign valid_o        = o_valid_q;
    assign alu_data_o     = o_q.alu_data;
    assign wdata_o        = o_q.wdata;
    assign rd_o           = o_q.rd;
    assign ctrl_o         = o_valid_q ? o_q.ctrl : 4'b0000;
    assign branch_taken_o = o_valid_q & o_q.branch & o_q.zero;
    assign btarget_o      = o_q.btarget;
    assign stall_cnt_o    = stall_cnt_q;

endmodule

// File: tb/tb_ex_mem_pipe.sv
// Directed bench for ex_mem_pipe: a queue of accepted entries serves as the scoreboard and
// a saturating counter model tracks stall cycles.
module tb_ex_mem_pipe;

    typedef struct packed {
        logic [31:0] alu;
        logic        zero;
        logic [31:0] wdata;
        logic [4:0]  rd;
        logic [3:0]  ctrl;
        logic        br;
        logic [31:0] bt;
    } ent_t;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic [31:0] alu_data_i = '0;
    logic        zero_i = 1'b0;
    logic [31:0] wdata_i = '0;
    logic [4:0]  rd_i = '0;
    logic [3:0]  ctrl_i = '0;
    logic        branch_i = 1'b0;
    logic [31:0] btarget_i = '0;
    logic        flush_i = 1'b0;
    logic        valid_o;
    logic        ready_i = 1'b0;
    logic [31:0] alu_data_o;
    logic [31:0] wdata_o;
    logic [4:0]  rd_o;
    logic [3:0]  ctrl_o;
    logic        branch_taken_o;
    logic [31:0] btarget_o;
    logic [15:0] stall_cnt_o;

    ex_mem_pipe #(
        .DATA_WIDTH(32),
        .REG_ADDR_W(5),
        .CNT_W(16)
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .valid_i(valid_i),
        .ready_o(ready_o),
        .alu_data_i(alu_data_i),
        .zero_i(zero_i),
        .wdata_i(wdata_i),
        .rd_i(rd_i),
        .ctrl_i(ctrl_i),
        .branch_i(branch_i),
        .btarget_i(btarget_i),
        .flush_i(flush_i),
        .valid_o(valid_o),
        .ready_i(ready_i),
        .alu_data_o(alu_data_o),
        .wdata_o(wdata_o),
        .rd_o(rd_o),
        .ctrl_o(ctrl_o),
        .branch_taken_o(branch_taken_o),
        .btarget_o(btarget_o),
        .stall_cnt_o(stall_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    ent_t        sb[$];
    logic [15:0] cnt_m = '0;
    int          total = 0;
    int          bad = 0;
    int          popped = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] alu, input logic z,
                         input logic [31:0] wd, input logic [4:0] rd, input logic [3:0] ctrl,
                         input logic br, input logic [31:0] bt);
        valid_i    = v;
        alu_data_i = alu;
        zero_i     = z;
        wdata_i    = wd;
        rd_i       = rd;
        ctrl_i     = ctrl;
        branch_i   = br;
        btarget_i  = bt;
    endtask

    task automatic check_outputs();
        ent_t e;
        chk("valid_o", 64'(valid_o), 64'(sb.size() > 0));
        chk("ready_o", 64'(ready_o), 64'(sb.size() < 2));
        chk("stall_cnt", 64'(stall_cnt_o), 64'(cnt_m));
        if (sb.size() > 0) begin
            e = sb[0];
            chk("alu_data_o", 64'(alu_data_o), 64'(e.alu));
            chk("wdata_o", 64'(wdata_o), 64'(e.wdata));
            chk("rd_o", 64'(rd_o), 64'(e.rd));
            chk("ctrl_o", 64'(ctrl_o), 64'(e.ctrl));
            chk("btarget_o", 64'(btarget_o), 64'(e.bt));
            chk("branch_taken", 64'(branch_taken_o), 64'(e.br & e.zero));
        end else begin
            chk("ctrl_o_bubble", 64'(ctrl_o), 64'(0));
            chk("branch_taken_bubble", 64'(branch_taken_o), 64'(0));
        end
    endtask

    // One clock: model decides transfers from pre-edge state, then the DUT is checked.
    task automatic cycle(input bit do_check);
        ent_t in_e;
        logic up, down;
        in_e = '{alu: alu_data_i, zero: zero_i, wdata: wdata_i, rd: rd_i, ctrl: ctrl_i,
                 br: branch_i, bt: btarget_i};
        up   = valid_i && (sb.size() < 2);
        down = (sb.size() > 0) && ready_i;
        if ((sb.size() > 0) && !ready_i && (cnt_m != 16'hFFFF)) cnt_m++;
        @(posedge clk_i);
        #1;
        if (flush_i) begin
            sb.delete();
        end else begin
            if (down) begin
                void'(sb.pop_front());
                popped++;
            end
            if (up) sb.push_back(in_e);
        end
        if (do_check) check_outputs();
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_valid_o", 64'(valid_o), 64'(0));
        chk("rst_ready_o", 64'(ready_o), 64'(1));
        chk("rst_stall_cnt", 64'(stall_cnt_o), 64'(0));
        chk("rst_alu_data_o", 64'(alu_data_o), 64'(0));
        chk("rst_branch_taken", 64'(branch_taken_o), 64'(0));
        rst_i = 1'b0;

        // 1: single entry, one cycle latency, then bubble
        ready_i = 1'b1;
        drive(1'b1, 32'h7, 1'b0, 32'hAA, 5'd3, 4'b1000, 1'b0, 32'h0);
        cycle(1'b1);
        chk("t1_valid", 64'(valid_o), 64'(1));
        chk("t1_alu", 64'(alu_data_o), 64'h7);
        chk("t1_rd", 64'(rd_o), 64'd3);
        chk("t1_ctrl", 64'(ctrl_o), 64'b1000);
        drive(1'b0, 32'h0, 1'b0, 32'h0, 5'd0, 4'b0000, 1'b0, 32'h0);
        cycle(1'b1);
        chk("t1_valid_after", 64'(valid_o), 64'(0));
        chk("t1_ctrl_after", 64'(ctrl_o), 64'(0));

        // 2: A, B, C with downstream stall from B
        popped = 0;
        drive(1'b1, 32'h10, 1'b0, 32'h110, 5'd1, 4'b1100, 1'b0, 32'h0);
        cycle(1'b1);
        ready_i = 1'b0;
        drive(1'b1, 32'h20, 1'b0, 32'h120, 5'd2, 4'b1010, 1'b0, 32'h0);
        cycle(1'b1);
        drive(1'b1, 32'h30, 1'b0, 32'h130, 5'd4, 4'b0001, 1'b0, 32'h0);
        cycle(1'b1);
        chk("t2_ready_low", 64'(ready_o), 64'(0));
        chk("t2_O_holds_A", 64'(alu_data_o), 64'h10);
        ready_i = 1'b1;
        cycle(1'b1);
        chk("t2_out_B", 64'(alu_data_o), 64'h20);
        chk("t2_ready_back", 64'(ready_o), 64'(1));
        cycle(1'b1);
        chk("t2_out_C", 64'(alu_data_o), 64'h30);
        drive(1'b0, 32'h0, 1'b0, 32'h0, 5'd0, 4'b0000, 1'b0, 32'h0);
        cycle(1'b1);
        chk("t2_drained", 64'(popped), 64'd3);

        // 3: branch resolution
        drive(1'b1, 32'h1, 1'b1, 32'h0, 5'd0, 4'b0000, 1'b1, 32'h40);
        cycle(1'b1);
        chk("t3_taken", 64'(branch_taken_o), 64'(1));
        chk("t3_target", 64'(btarget_o), 64'h40);
        drive(1'b1, 32'h2, 1'b0, 32'h0, 5'd0, 4'b0000, 1'b1, 32'h44);
        cycle(1'b1);
        chk("t3_not_taken", 64'(branch_taken_o), 64'(0));
        drive(1'b0, 32'h0, 1'b0, 32'h0, 5'd0, 4'b0000, 1'b0, 32'h0);
        cycle(1'b1);

        // 4: flush with both entries full and a valid input offered
        ready_i = 1'b0;
        drive(1'b1, 32'h50, 1'b0, 32'h1, 5'd5, 4'b1001, 1'b0, 32'h0);
        cycle(1'b1);
        drive(1'b1, 32'h60, 1'b0, 32'h2, 5'd6, 4'b0101, 1'b0, 32'h0);
        cycle(1'b1);
        chk("t4_full", 64'(ready_o), 64'(0));
        flush_i = 1'b1;
        ready_i = 1'b1;
        drive(1'b1, 32'h70, 1'b1, 32'h3, 5'd7, 4'b1111, 1'b1, 32'h0);
        cycle(1'b1);
        flush_i = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 32'h0, 5'd0, 4'b0000, 1'b0, 32'h0);
        chk("t4_valid", 64'(valid_o), 64'(0));
        chk("t4_ready", 64'(ready_o), 64'(1));
        chk("t4_ctrl", 64'(ctrl_o), 64'(0));
        cycle(1'b1);
        chk("t4_no_ghost", 64'(valid_o), 64'(0));

        // 5: long stall saturates the counter without wrapping
        ready_i = 1'b0;
        drive(1'b1, 32'h80, 1'b0, 32'h0, 5'd8, 4'b1000, 1'b0, 32'h0);
        cycle(1'b1);
        drive(1'b0, 32'h0, 1'b0, 32'h0, 5'd0, 4'b0000, 1'b0, 32'h0);
        for (int i = 0; i < 65600; i++) begin
            cycle((i % 256 == 0) || (i > 65500));
        end
        chk("t5_saturated", 64'(stall_cnt_o), 64'hFFFF);

        // 6: async reset mid-stall with skid full
        drive(1'b1, 32'h90, 1'b0, 32'h0, 5'd9, 4'b0100, 1'b0, 32'h0);
        cycle(1'b1);
        drive(1'b0, 32'h0, 1'b0, 32'h0, 5'd0, 4'b0000, 1'b0, 32'h0);
        chk("t6_skid_full", 64'(ready_o), 64'(0));
        #2;
        rst_i = 1'b1;
        #1;
        chk("t6_valid", 64'(valid_o), 64'(0));
        chk("t6_ready", 64'(ready_o), 64'(1));
        chk("t6_cnt", 64'(stall_cnt_o), 64'(0));
        sb.delete();
        cnt_m = '0;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        cycle(1'b1);
        chk("t6_after_release", 64'(valid_o), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ex_mem_pipe.md
Name: ex_mem_pipe

Overview:
- EX/MEM pipeline stage directly downstream of the ALU in the pipelined CPU.
- Captures the ALU result and Zero flag, together with store data, destination register, branch target and MEM/WB control bits, into a registered output presented to the MEM stage.
- Uses a valid/ready handshake with a 2-entry skid buffer, so a downstream memory stall does not lose the in-flight EX result.
- Resolves branches (Branch & Zero) from the registered entry and keeps a saturating stall-cycle counter.

Parameters:
DATA_WIDTH, 32, width of ALU result, store data and branch target
REG_ADDR_W, 5, width of destination register address
CNT_W, 16, width of stall counter

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  reset, asynchronous, active-high
valid_i  input  1  EX stage presents a valid entry
ready_o  output  1  stage can accept an entry this cycle
alu_data_i  input  DATA_WIDTH  ALU data_o
zero_i  input  1  ALU Zero_o
wdata_i  input  DATA_WIDTH  store data (rt value)
rd_i  input  REG_ADDR_W  destination register
ctrl_i  input  4  {RegWrite, MemtoReg, MemRead, MemWrite}
branch_i  input  1  instruction is beq-type
btarget_i  input  DATA_WIDTH  branch target address
flush_i  input  1  kill all held entries
valid_o  output  1  output entry valid
ready_i  input  1  MEM stage accepts output entry
alu_data_o  output  DATA_WIDTH  registered ALU result
wdata_o  output  DATA_WIDTH  registered store data
rd_o  output  REG_ADDR_W  registered destination
ctrl_o  output  4  registered control; forced 0 when valid_o=0
branch_taken_o  output  1  valid_o & branch & zero of output entry
btarget_o  output  DATA_WIDTH  registered branch target
stall_cnt_o  output  CNT_W  saturating count of stall cycles

Behaviour:
- Storage: output register (O) and skid register (S), each holding a full entry plus a valid bit.
- Reset (async, rst_i=1):
  - O.valid=0, S.valid=0, ready_o=1, stall_cnt_o=0.
  - All data fields are 0 and branch_taken_o=0.
- Reset mid-operation drops any held entries; no partial output is seen after reset releases.
- ready_o = !S.valid. It is registered state and never depends combinationally on ready_i.
- Upstream transfer: valid_i & ready_o at the clock edge.
- Downstream transfer: valid_o & ready_i at the clock edge.
- Per-edge update when flush_i=0:
  - O empty or downstream transfer, S valid: O<=S; S.valid<=0. If an upstream transfer also occurs it loads S (only possible when ready_o was 1, i.e. S was empty, so this case does not arise).
  - O empty or downstream transfer, S empty: O<=input if upstream transfer, else O.valid<=0.
  - O valid, no downstream transfer, upstream transfer: S<=input; ready_o falls to 0 on the next cycle.
  - O valid, no downstream transfer, no upstream transfer: hold.
- Ordering is strictly FIFO: an entry in S always leaves before any later input.
- Latency: 1 cycle from upstream transfer to valid_o when the stage is empty.
- Throughput: 1 entry per cycle while ready_i=1.
- flush_i=1: O.valid<=0 and S.valid<=0 at the edge, with priority over every transfer. The input offered that cycle is discarded even if valid_i & ready_o. ready_o=1 on the next cycle.
- ctrl_o and branch_taken_o are gated by valid_o, so bubbles never write registers or memory.
- Data fields of O/S need not be cleared on flush.
- stall_cnt_o increments on each edge where valid_o=1 and ready_i=0, saturates at all-ones, and never wraps. It is not affected by flush.
- No arithmetic beyond the counter; all fields pass through unmodified.

Test Plan:
1. Reset, then valid_i=1, alu_data_i=0x00000007, rd_i=3, ctrl_i=4'b1000, ready_i=1 for one cycle -> next cycle valid_o=1, alu_data_o=0x7, rd_o=3, ctrl_o=4'b1000; the cycle after, valid_o=0 and ctrl_o=0.
2. Back-to-back stream A=0x10, B=0x20, C=0x30 with ready_i=0 from the cycle B arrives -> O holds A, S holds B, ready_o=0, C is not accepted. Raise ready_i -> outputs A, B, C in order on consecutive cycles, and ready_o returns to 1.
3. branch_i=1, zero_i=1, btarget_i=0x00000040 -> branch_taken_o=1 and btarget_o=0x40 while valid_o=1. With zero_i=0 -> branch_taken_o=0.
4. O and S both full, then flush_i=1 with valid_i=1 -> next cycle valid_o=0, ready_o=1, ctrl_o=0; the flushed-cycle input never appears at the output.
5. Hold valid_o=1, ready_i=0 for 70000 cycles with CNT_W=16 -> stall_cnt_o saturates at 0xFFFF and does not wrap.
6. Assert rst_i asynchronously mid-stall with S full -> valid_o=0, ready_o=1 and stall_cnt_o=0 immediately, without waiting for a clock edge.
